// File: rtl/universal_gate_unit.sv
// WIDTH-bit registered logic unit: eight bitwise functions built from a NAND cell,
// a one-deep valid/ready output register and a truth-table self-test sequencer.
module universal_gate_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [2:0]       y_op,
   input  logic             bist_start,
   input  logic             bist_inject,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CHECK
   } state_t;

   // Expected result bit indexed by {op, a, b}; one nibble per function, NAND in the low nibble.
   localparam logic [31:0] GOLD = 32'hC396_E817;

   state_t           state_q;
   logic [4:0]       k_q;
   logic             fail_q;
   logic             done_q;
   logic             pass_q;
   logic             cmpValid_q;
   logic [WIDTH-1:0] cmpRes_q;
   logic [WIDTH-1:0] cmpGold_q;

   logic             outValid_q, outValid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [2:0]       yOp_q, yOp_d;

   logic             busy;
   logic             inReady;
   logic             transfer;
   logic             mismatch;
   logic [2:0]       opSel;
   logic [WIDTH-1:0] aSel, bSel;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] injMask;

   logic [WIDTH-1:0] notA, notB, nandAB, andAB, orAB, norAB;
   logic [WIDTH-1:0] xorN2, xorN3, xorAB, xnorAB, bufA;

   function automatic logic [WIDTH-1:0] nandCell(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
      return ~(x & z);
   endfunction

   // The done cycle still counts as busy so the sequencer cannot be re-armed until it drops.
   assign busy      = (state_q != IDLE) || done_q;
   assign inReady   = !busy && (!outValid_q || out_ready);
   assign transfer  = in_valid && inReady;
   assign mismatch  = (cmpRes_q != cmpGold_q);

   assign opSel = busy ? k_q[4:2] : op;
   assign aSel  = busy ? {WIDTH{k_q[1]}} : a;
   assign bSel  = busy ? {WIDTH{k_q[0]}} : b;

   always_comb begin
      notA   = nandCell(aSel, aSel);
      notB   = nandCell(bSel, bSel);
      nandAB = nandCell(aSel, bSel);
      andAB  = nandCell(nandAB, nandAB);
      orAB   = nandCell(notA, notB);
      norAB  = nandCell(orAB, orAB);
      xorN2  = nandCell(aSel, nandAB);
      xorN3  = nandCell(bSel, nandAB);
      xorAB  = nandCell(xorN2, xorN3);
      xnorAB = nandCell(xorAB, xorAB);
      bufA   = nandCell(notA, notA);
      unique case (opSel)
         3'd0:    result = nandAB;
         3'd1:    result = norAB;
         3'd2:    result = andAB;
         3'd3:    result = orAB;
         3'd4:    result = xorAB;
         3'd5:    result = xnorAB;
         3'd6:    result = notA;
         default: result = bufA;
      endcase
   end

   always_comb begin
      injMask    = '0;
      injMask[0] = bist_inject;
   end

   // Self-test: each RUN cycle captures one vector and checks the one captured the cycle before.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         fail_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         cmpValid_q <= 1'b0;
         cmpRes_q   <= '0;
         cmpGold_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bist_start && !outValid_q && !done_q) begin
                  state_q    <= RUN;
                  k_q        <= '0;
                  fail_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  cmpValid_q <= 1'b0;
               end
            end
            RUN: begin
               cmpRes_q   <= result ^ injMask;
               cmpGold_q  <= {WIDTH{GOLD[k_q]}};
               cmpValid_q <= 1'b1;
               if (cmpValid_q && mismatch) fail_q <= 1'b1;
               k_q <= k_q + 5'd1;
               if (k_q == 5'd31) state_q <= CHECK;
            end
            CHECK: begin
               done_q     <= 1'b1;
               pass_q     <= !(fail_q || mismatch);
               fail_q     <= fail_q || mismatch;
               cmpValid_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      outValid_d = outValid_q;
      y_d        = y_q;
      yOp_d      = yOp_q;
      if (transfer) begin
         outValid_d = 1'b1;
         y_d        = result;
         yOp_d      = opSel;
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid_q <= 1'b0;
         y_q        <= '0;
         yOp_q      <= '0;
      end else begin
         outValid_q <= outValid_d;
         y_q        <= y_d;
         yOp_q      <= yOp_d;
      end
   end

   assign in_ready  = inReady;
   assign out_valid = outValid_q;
   assign y         = y_q;
   assign y_op      = yOp_q;
   assign bist_busy = busy;
   assign bist_done = done_q;
   assign bist_pass = pass_q;

endmodule

// File: tb/tb_universal_gate_unit.sv
// Directed self-checking bench for universal_gate_unit (WIDTH=8): datapath, handshake and self-test.
module tb_universal_gate_unit;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic [2:0]       y_op;
   logic             bist_start;
   logic             bist_inject;
   logic             bist_busy;
   logic             bist_done;
   logic             bist_pass;

   int vectors = 0;
   int miscompares = 0;

   universal_gate_unit #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .op         (op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y          (y),
      .y_op       (y_op),
      .bist_start (bist_start),
      .bist_inject(bist_inject),
      .bist_busy  (bist_busy),
      .bist_done  (bist_done),
      .bist_pass  (bist_pass)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
      bist_start = 1'b0; bist_inject = 1'b0;
      tick(); tick();
      vectors++;
      if ({in_ready, out_valid, y, y_op, bist_busy, bist_done, bist_pass} !== {1'b1, 1'b0, 8'h00, 3'd0, 3'b000}) begin
         miscompares++;
         $display("[TB] FAIL reset: got rdy=%b ov=%b y=%h op=%0d busy=%b done=%b pass=%b, need 1 0 00 0 0 0 0",
                  in_ready, out_valid, y, y_op, bist_busy, bist_done, bist_pass);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_nand_truth();
      logic [7:0] av [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
      logic [7:0] bv [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
      logic [7:0] ev [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = av[i]; b = bv[i]; op = 3'd0; out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         vectors++;
         if (out_valid !== 1'b1 || y !== ev[i]) begin
            miscompares++;
            $display("[TB] FAIL nand_%0d: got ov=%b y=%h, need ov=1 y=%h", i, out_valid, y, ev[i]);
         end
         tick();
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nand_drain_%0d: got ov=%b, need 0", i, out_valid);
         end
      end
   endtask

   task automatic test_op_sweep();
      logic [7:0] ev [8] = '{8'hDB, 8'h42, 8'h24, 8'hBD, 8'h99, 8'h66, 8'h5A, 8'hA5};
      a = 8'hA5; b = 8'h3C; out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         tick();
         vectors++;
         if (out_valid !== 1'b1 || y !== ev[i] || y_op !== 3'(i)) begin
            miscompares++;
            $display("[TB] FAIL op_sweep_%0d: got ov=%b y=%h y_op=%0d, need ov=1 y=%h y_op=%0d",
                     i, out_valid, y, y_op, ev[i], i);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; a = 8'h0F; b = 8'hF0; op = 3'd3; out_ready = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || y !== 8'hFF || in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_first: got ov=%b y=%h rdy=%b, need ov=1 y=ff rdy=0", out_valid, y, in_ready);
      end
      a = 8'h0F; b = 8'h0F; op = 3'd4;
      tick();
      vectors++;
      if (y !== 8'hFF || y_op !== 3'd3 || out_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bp_hold: got y=%h y_op=%0d ov=%b, need y=ff y_op=3 ov=1", y, y_op, out_valid);
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bp_ready_comb: got rdy=%b, need 1", in_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || y !== 8'h00 || y_op !== 3'd4) begin
         miscompares++;
         $display("[TB] FAIL bp_second: got ov=%b y=%h y_op=%0d, need ov=1 y=00 y_op=4", out_valid, y, y_op);
      end
      in_valid = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_drain: got ov=%b, need 0", out_valid);
      end
   endtask

   // injectAt < 0 means no fault injection; otherwise inject for the edge after sample injectAt.
   task automatic test_bist(input string name, input int injectAt, input logic expPass);
      int busyCount = 0;
      int doneCount = 0;
      int doneIdx = -1;
      logic passAtDone = 1'b0;
      logic ovSeen = 1'b0;
      logic rdySeen = 1'b0;
      out_ready = 1'b1; in_valid = 1'b0;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      in_valid = 1'b1; a = 8'hFF; b = 8'h00; op = 3'd3;
      for (int i = 0; i < 60; i++) begin
         if (bist_busy) busyCount++;
         if (bist_busy && in_ready) rdySeen = 1'b1;
         if (out_valid) ovSeen = 1'b1;
         if (bist_done) begin
            doneCount++;
            if (doneIdx < 0) begin
               doneIdx = i;
               passAtDone = bist_pass;
            end
         end
         if (!bist_busy && i > 0) break;
         bist_inject = (i == injectAt);
         tick();
      end
      bist_inject = 1'b0;
      in_valid = 1'b0;
      vectors++;
      if (busyCount !== 34 || doneCount !== 1 || doneIdx !== 33) begin
         miscompares++;
         $display("[TB] FAIL %s_timing: got busy=%0d done_count=%0d done_at=%0d, need 34 1 33",
                  name, busyCount, doneCount, doneIdx);
      end
      vectors++;
      if (passAtDone !== expPass || bist_pass !== expPass) begin
         miscompares++;
         $display("[TB] FAIL %s_pass: got at_done=%b now=%b, need %b", name, passAtDone, bist_pass, expPass);
      end
      vectors++;
      if (ovSeen !== 1'b0 || rdySeen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s_isolation: got ov_seen=%b rdy_while_busy=%b, need 0 0", name, ovSeen, rdySeen);
      end
      tick();
   endtask

   task automatic test_reset_mid_bist();
      logic doneSeen = 1'b0;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bist_busy, bist_done, bist_pass, in_ready, out_valid} !== 5'b00010) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_bist: got busy=%b done=%b pass=%b rdy=%b ov=%b, need 0 0 0 1 0",
                  bist_busy, bist_done, bist_pass, in_ready, out_valid);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bist_done || bist_busy) doneSeen = 1'b1;
         tick();
      end
      vectors++;
      if (doneSeen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_no_done: got activity=%b, need 0", doneSeen);
      end
   endtask

   task automatic test_start_ignored();
      in_valid = 1'b1; a = 8'hC3; b = 8'h00; op = 3'd7; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      tick();
      vectors++;
      if (bist_busy !== 1'b0 || out_valid !== 1'b1 || y !== 8'hC3 || y_op !== 3'd7) begin
         miscompares++;
         $display("[TB] FAIL start_ignored: got busy=%b ov=%b y=%h y_op=%0d, need 0 1 c3 7",
                  bist_busy, out_valid, y, y_op);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || y !== 8'h00 || y_op !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL rst_pending: got ov=%b y=%h y_op=%0d, need 0 00 0", out_valid, y, y_op);
      end
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_nand_truth();
      test_op_sweep();
      test_back_to_back();
      test_bist("bist_clean", -1, 1'b1);
      test_bist("bist_inject", 12, 1'b0);
      test_bist("bist_reclean", -1, 1'b1);
      test_reset_mid_bist();
      test_start_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
